// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcode constants and the datapath mux-select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALUB_RT      = 2'b00,
    ALUB_FOUR    = 2'b01,
    ALUB_IMM     = 2'b10,
    ALUB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  // Every datapath select and enable the FSM drives, in one bundle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_source;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_perf_counters.sv
// Cycle and retired-instruction counters for the multi-cycle controller.
// Both wrap freely; cycles are not counted while the FSM sits in IDLE.
module mips_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_idle,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (!in_idle) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)   instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore output decode with
// ready-gated PC/IR loads in FETCH, memory-ready stalls and perf counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e state, next_state;
  ctrl_t  ctl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         illegal_op <= 1'b0;
    else if (state == S_DECODE && !is_supported(opcode)) illegal_op <= 1'b1;
  end

  // Outputs depend on state only (plus mem_ready in FETCH), so an async reset
  // drops every enable in the same instant the state returns to IDLE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    next_state = state;
    ctl        = '0;
    retire     = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PC_ALU;
        ctl.pc_write  = mem_ready;
        ctl.ir_write  = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_src_b = ALUB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        next_state    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl.i_or_d   = 1'b1;
        ctl.mem_read = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        retire         = 1'b1;
        next_state     = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_RT;
        ctl.alu_op    = ALU_FUNCT;
        next_state    = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        retire        = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = ALUB_RT;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PC_ALUOUT;
        retire            = 1'b1;
        next_state        = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PC_JUMP;
        retire        = 1'b1;
        next_state    = S_FETCH;
      end
      S_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        next_state    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctl.reg_write = 1'b1;
        retire        = 1'b1;
        next_state    = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;

  mips_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_idle   (state == S_IDLE),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control words are
// compared against hand-encoded vectors for each instruction class.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 32;

  // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  // alu_op[1:0], pc_source[1:0]}
  localparam logic [15:0] W_IDLE     = 16'h0000;
  localparam logic [15:0] W_FETCH    = 16'h9410;
  localparam logic [15:0] W_FETCH_WT = 16'h1010;
  localparam logic [15:0] W_DECODE   = 16'h0030;
  localparam logic [15:0] W_MEM_ADDR = 16'h0060;
  localparam logic [15:0] W_MEM_RD   = 16'h3000;
  localparam logic [15:0] W_MEM_WB   = 16'h0280;
  localparam logic [15:0] W_MEM_WR   = 16'h2800;
  localparam logic [15:0] W_EXEC     = 16'h0048;
  localparam logic [15:0] W_R_WB     = 16'h0180;
  localparam logic [15:0] W_BRANCH   = 16'h4045;
  localparam logic [15:0] W_JUMP     = 16'h8002;
  localparam logic [15:0] W_ADDI_EX  = 16'h0060;
  localparam logic [15:0] W_ADDI_WB  = 16'h0080;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             illegal_op;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
  );

  function automatic logic [15:0] ctl_word();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    @(posedge clk); #1;
    checks++;
    if (ctl_word() !== W_IDLE) begin
      errors++; $display("FAIL reset_ctl: got %h expected %h", ctl_word(), W_IDLE);
    end
    checks++;
    if (cycle_cnt !== '0 || instr_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
    end
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_op);
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_word() !== W_IDLE) begin
      errors++; $display("FAIL idle_after_release: got %h expected %h", ctl_word(), W_IDLE);
    end
  endtask

  task automatic test_rtype();
    logic [15:0] exp_w [5] = '{W_FETCH, W_DECODE, W_EXEC, W_R_WB, W_FETCH};
    opcode = 6'h00; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL rtype_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
    end
    checks++;
    if (instr_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
      errors++; $display("FAIL rtype_cnt: got instr %0d cyc %0d expected 1 4", instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [15:0] exp_w [10] = '{W_FETCH_WT, W_FETCH_WT, W_FETCH, W_DECODE, W_MEM_ADDR,
                                W_MEM_RD, W_MEM_RD, W_MEM_RD, W_MEM_RD, W_MEM_WB};
    logic        rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int pw_n = 0;
    int ir_n = 0;
    opcode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL lw_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
      pw_n += int'(pc_write);
      ir_n += int'(ir_write);
      @(posedge clk); #1;
    end
    checks++;
    if (pw_n != 1 || ir_n != 1) begin
      errors++; $display("FAIL lw_pulses: got pc_write %0d ir_write %0d expected 1 1", pw_n, ir_n);
    end
    checks++;
    if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd14) begin
      errors++; $display("FAIL lw_cnt: got instr %0d cyc %0d expected 2 14", instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_sw();
    logic [15:0] exp_w [4] = '{W_FETCH, W_DECODE, W_MEM_ADDR, W_MEM_WR};
    logic [5:0]  ops [4]   = '{6'h2B, 6'h2B, 6'h2B, 6'h3F};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = ops[i];
      #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL sw_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd18 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL sw_cnt: got instr %0d cyc %0d ill %b expected 3 18 0",
                         instr_cnt, cycle_cnt, illegal_op);
    end
  endtask

  task automatic test_beq_j();
    logic [15:0] exp_w [6] = '{W_FETCH, W_DECODE, W_BRANCH, W_FETCH, W_DECODE, W_JUMP};
    logic [5:0]  ops [6]   = '{6'h04, 6'h04, 6'h04, 6'h02, 6'h02, 6'h02};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i];
      #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL beq_j_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instr_cnt !== 32'd5 || cycle_cnt !== 32'd24) begin
      errors++; $display("FAIL beq_j_cnt: got instr %0d cyc %0d expected 5 24", instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_illegal_then_addi();
    logic [15:0] exp_w [6] = '{W_FETCH, W_DECODE, W_FETCH, W_DECODE, W_ADDI_EX, W_ADDI_WB};
    logic [5:0]  ops [6]   = '{6'h3F, 6'h3F, 6'h08, 6'h08, 6'h08, 6'h08};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i];
      #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL illegal_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
      @(posedge clk); #1;
      if (i == 1) begin
        checks++;
        if (illegal_op !== 1'b1 || instr_cnt !== 32'd5) begin
          errors++; $display("FAIL illegal_flag: got ill %b instr %0d expected 1 5", illegal_op, instr_cnt);
        end
      end
    end
    checks++;
    if (illegal_op !== 1'b1 || instr_cnt !== 32'd6 || cycle_cnt !== 32'd30) begin
      errors++; $display("FAIL addi_cnt: got ill %b instr %0d cyc %0d expected 1 6 30",
                         illegal_op, instr_cnt, cycle_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] exp_w [3] = '{W_FETCH, W_DECODE, W_MEM_ADDR};
    opcode = 6'h2B; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl_word() !== exp_w[i]) begin
        errors++; $display("FAIL rstmid_ctl cycle %0d: got %h expected %h", i, ctl_word(), exp_w[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ctl_word() !== W_MEM_WR) begin
      errors++; $display("FAIL rstmid_wait: got %h expected %h", ctl_word(), W_MEM_WR);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || ctl_word() !== W_IDLE) begin
      errors++; $display("FAIL rstmid_async: got mem_write %b ctl %h expected 0 %h",
                         mem_write, ctl_word(), W_IDLE);
    end
    checks++;
    if (cycle_cnt !== '0 || instr_cnt !== '0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL rstmid_cnt: got cyc %0d instr %0d ill %b expected 0 0 0",
                         cycle_cnt, instr_cnt, illegal_op);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_word() !== W_IDLE) begin
      errors++; $display("FAIL rstmid_idle: got %h expected %h", ctl_word(), W_IDLE);
    end
    @(posedge clk); #1;
    checks++;
    if (ctl_word() !== W_FETCH || cycle_cnt !== '0) begin
      errors++; $display("FAIL rstmid_fetch: got ctl %h cyc %0d expected %h 0",
                         ctl_word(), cycle_cnt, W_FETCH);
    end
    @(posedge clk); #1;
    checks++;
    if (ctl_word() !== W_DECODE || cycle_cnt !== 32'd1) begin
      errors++; $display("FAIL rstmid_decode: got ctl %h cyc %0d expected %h 1",
                         ctl_word(), cycle_cnt, W_DECODE);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq_j();
    test_illegal_then_addi();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
